circuit1_sweep: RTL and testbench

Sequential exhaustive tester that drives the four inputs (w, x, y, z) of the lab's 4-input combinational circuit and reads back its single output f. On a start request it steps through all 16 input combinations, waits a configurable settle time per vector, samples f, builds the observed 16-entry truth table, and compares it against an expected minterm mask. It sits between the board-level start button / result LEDs and the circuit under test, and is the driver-and-reader counterpart to that circuit's interface.

---
 rtl/circuit1_sweep_if.sv | 48 ++++
 rtl/circuit1_sweep.sv | 181 ++++++++++++++++++
 tb/tb_circuit1_sweep.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/circuit1_sweep_if.sv
// Signal bundle between the exhaustive sweep tester and its environment:
// start request and circuit output in, stimulus and results out.
interface circuit1_sweep_if;
    logic        start;
    logic        f;
    logic        w;
    logic        x;
    logic        y;
    logic        z;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] truth_table;
    logic [4:0]  mismatch_count;
    logic [3:0]  fail_index;

    // Tester side: drives stimulus and results, reads start and f.
    modport master (
        input  start,
        input  f,
        output w,
        output x,
        output y,
        output z,
        output busy,
        output done,
        output pass,
        output truth_table,
        output mismatch_count,
        output fail_index
    );

    // Environment side: the start button and the circuit under test.
    modport slave (
        output start,
        output f,
        input  w,
        input  x,
        input  y,
        input  z,
        input  busy,
        input  done,
        input  pass,
        input  truth_table,
        input  mismatch_count,
        input  fail_index
    );
endinterface

// File: rtl/circuit1_sweep.sv
// Exhaustive 16-vector tester for a 4-input combinational circuit: drives each
// vector, waits SETTLE cycles, samples f and compares against EXPECTED.
module circuit1_sweep #(
    parameter int unsigned SETTLE   = 1,
    parameter logic [15:0] EXPECTED = 16'h6879
) (
    input  logic              clk,
    input  logic              rst,
    circuit1_sweep_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_L = SETTLE[3:0];

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  settle_cnt_q, settle_cnt_d;
    logic [15:0] truth_table_q, truth_table_d;
    logic [4:0]  mismatch_count_q, mismatch_count_d;
    logic [3:0]  fail_index_q, fail_index_d;
    logic        first_fail_q, first_fail_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [3:0]  vec_q, vec_d;
    logic        launch_s;
    logic        miss_s;

    assign launch_s = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.start;
    assign miss_s   = (bus.f != EXPECTED[idx_q]);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a zero settle time skips WAIT entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (launch_s) begin
                    state_d = (SETTLE_L == 4'd0) ? ST_SAMPLE : ST_WAIT;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WAIT: begin
                if (settle_cnt_q <= 4'd1) begin
                    state_d = ST_SAMPLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_SAMPLE: begin
                if (idx_q == 4'd15) begin
                    state_d = ST_DONE;
                end else if (SETTLE_L == 4'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and next values of the registered outputs.
    always_comb begin
        idx_d            = idx_q;
        settle_cnt_d     = settle_cnt_q;
        truth_table_d    = truth_table_q;
        mismatch_count_d = mismatch_count_q;
        fail_index_d     = fail_index_q;
        first_fail_d     = first_fail_q;
        pass_d           = pass_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (launch_s) begin
                    idx_d            = 4'd0;
                    settle_cnt_d     = SETTLE_L;
                    truth_table_d    = 16'd0;
                    mismatch_count_d = 5'd0;
                    fail_index_d     = 4'd0;
                    first_fail_d     = 1'b0;
                    pass_d           = 1'b0;
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_WAIT: begin
                if (settle_cnt_q != 4'd0) begin
                    settle_cnt_d = settle_cnt_q - 4'd1;
                end else begin
                    settle_cnt_d = 4'd0;
                end
            end
            ST_SAMPLE: begin
                truth_table_d[idx_q] = bus.f;
                if (miss_s) begin
                    mismatch_count_d = mismatch_count_q + 5'd1;
                    if (!first_fail_q) begin
                        fail_index_d = idx_q;
                        first_fail_d = 1'b1;
                    end else begin
                        fail_index_d = fail_index_q;
                    end
                end else begin
                    mismatch_count_d = mismatch_count_q;
                end
                // Last vector: latch the verdict as DONE is entered.
                if (idx_q == 4'd15) begin
                    pass_d = (mismatch_count_d == 5'd0);
                end else begin
                    idx_d        = idx_q + 4'd1;
                    settle_cnt_d = SETTLE_L;
                end
            end
            default: begin
                idx_d = 4'd0;
            end
        endcase

        busy_d = (state_d == ST_WAIT) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
        if (busy_d) begin
            vec_d = idx_d;
        end else begin
            vec_d = 4'd0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q            <= 4'd0;
            settle_cnt_q     <= 4'd0;
            truth_table_q    <= 16'd0;
            mismatch_count_q <= 5'd0;
            fail_index_q     <= 4'd0;
            first_fail_q     <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            vec_q            <= 4'd0;
        end else begin
            idx_q            <= idx_d;
            settle_cnt_q     <= settle_cnt_d;
            truth_table_q    <= truth_table_d;
            mismatch_count_q <= mismatch_count_d;
            fail_index_q     <= fail_index_d;
            first_fail_q     <= first_fail_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            vec_q            <= vec_d;
        end
    end

    assign bus.w              = vec_q[3];
    assign bus.x              = vec_q[2];
    assign bus.y              = vec_q[1];
    assign bus.z              = vec_q[0];
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.truth_table    = truth_table_q;
    assign bus.mismatch_count = mismatch_count_q;
    assign bus.fail_index     = fail_index_q;

endmodule

// File: tb/tb_circuit1_sweep.sv
// Bench for circuit1_sweep: three testers (SETTLE 1, 0, 3) each driving a
// table-defined circuit model, checked against a truth-table reference.
module tb_circuit1_sweep;

    localparam logic [15:0] EXP_TT = 16'h6879;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start_v;
    logic [2:0]  lat;
    logic [15:0] tbl [3];
    logic [2:0]  busy_o, done_o, pass_o, any_o;
    logic [3:0]  vec_o [3];
    logic [3:0]  fi_o [3];
    logic [15:0] tt_o [3];
    logic [4:0]  mc_o [3];
    logic [15:0] good_tbl;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned S = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        circuit1_sweep_if bus_i ();
        logic p1, p2;

        circuit1_sweep #(.SETTLE(S), .EXPECTED(EXP_TT)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus_i)
        );

        // Circuit under test: a lookup table, optionally behind two registers.
        always @(posedge clk) begin
            p1 <= tbl[g][vec_o[g]];
            p2 <= p1;
        end
        assign bus_i.start = start_v[g];
        assign bus_i.f     = lat[g] ? p2 : tbl[g][vec_o[g]];
        assign vec_o[g]    = {bus_i.w, bus_i.x, bus_i.y, bus_i.z};
        assign busy_o[g]   = bus_i.busy;
        assign done_o[g]   = bus_i.done;
        assign pass_o[g]   = bus_i.pass;
        assign tt_o[g]     = bus_i.truth_table;
        assign mc_o[g]     = bus_i.mismatch_count;
        assign fi_o[g]     = bus_i.fail_index;
        assign any_o[g]    = |{vec_o[g], bus_i.busy, bus_i.done, bus_i.pass,
                               bus_i.truth_table, bus_i.mismatch_count, bus_i.fail_index};
    end

    function automatic int settle_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // One full sweep on tester k; start is pulsed again at cycle 'poke' (if >= 0).
    task automatic run_sweep(input int k, input int poke);
        int per;
        per = settle_of(k) + 1;
        @(negedge clk);
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        for (int n = 0; n < 16 * per; n++) begin
            check_eq("busy", 32'(busy_o[k]), 32'd1);
            check_eq("done_low", 32'(done_o[k]), 32'd0);
            check_eq("vector", 32'(vec_o[k]), 32'(n / per));
            if (n == 0) begin
                check_eq("clr_tt", 32'(tt_o[k]), 32'd0);
                check_eq("clr_mc", 32'(mc_o[k]), 32'd0);
            end
            start_v[k] = (n == poke);
            @(negedge clk);
        end
        start_v[k] = 1'b0;
        check_eq("busy_end", 32'(busy_o[k]), 32'd0);
        check_eq("done", 32'(done_o[k]), 32'd1);
        check_eq("vec_done", 32'(vec_o[k]), 32'd0);
    endtask

    task automatic check_results(input int k, input logic [15:0] circ);
        logic [15:0] diff;
        int cnt, first;
        bit found;
        diff = circ ^ EXP_TT;
        cnt = 0; first = 0; found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (diff[i]) begin
                cnt++;
                if (!found) begin
                    first = i;
                    found = 1'b1;
                end
            end
        end
        check_eq("truth_table", 32'(tt_o[k]), 32'(circ));
        check_eq("mismatch_count", 32'(mc_o[k]), 32'(cnt));
        check_eq("fail_index", 32'(fi_o[k]), 32'(first));
        check_eq("pass", 32'(pass_o[k]), 32'(cnt == 0));
    endtask

    initial begin
        logic [3:0] v;
        bit saw_done;
        for (int i = 0; i < 16; i++) begin
            v = i[3:0];
            good_tbl[i] = (~v[3] & ~v[1] & ~v[0]) | (v[2] & (v[1] ^ v[0])) | (~v[2] & v[1] & v[0]);
        end
        lat = 3'b000;
        for (int k = 0; k < 3; k++) tbl[k] = good_tbl;

        // Reset wins over start.
        rst = 1'b1;
        start_v = 3'b111;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) check_eq("reset_outs", 32'(any_o[k]), 32'd0);
        start_v = 3'b000;
        rst = 1'b0;
        @(negedge clk);
        check_eq("busy_after_rst", 32'(busy_o), 32'd0);
        check_eq("done_after_rst", 32'(done_o), 32'd0);

        // Correct, stuck-at-0 and inverted circuits; later sweeps start from DONE.
        run_sweep(0, -1);
        check_results(0, good_tbl);
        tbl[0] = 16'h0000;
        run_sweep(0, -1);
        check_results(0, 16'h0000);
        tbl[0] = ~good_tbl;
        run_sweep(0, -1);
        check_results(0, ~good_tbl);

        // Start while busy (during vector 5) is ignored.
        tbl[0] = good_tbl;
        run_sweep(0, 10);
        check_results(0, good_tbl);

        // Random circuits on every settle setting.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++) begin
                tbl[k] = 16'($urandom);
                run_sweep(k, -1);
                check_results(k, tbl[k]);
            end
        end

        // Mid-sweep reset at vector 9, no done afterwards, then a clean sweep.
        tbl[0] = good_tbl;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (18) @(negedge clk);
        check_eq("vec9", 32'(vec_o[0]), 32'd9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) check_eq("midrst_outs", 32'(any_o[k]), 32'd0);
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done_o[0] || busy_o[0]) saw_done = 1'b1;
        end
        check_eq("no_done_after_abort", 32'(saw_done), 32'd0);
        run_sweep(0, -1);
        check_results(0, good_tbl);

        // Two-cycle latency circuit: enough settle time at 3, not at 0.
        lat = 3'b110;
        tbl[1] = good_tbl;
        tbl[2] = good_tbl;
        run_sweep(2, -1);
        check_results(2, good_tbl);
        run_sweep(1, -1);
        check_eq("latency_settle0_pass", 32'(pass_o[1]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
